// File: rtl/monotonic_counter_bank.sv
// Bank of increment-only counters with lock, atomic check-and-advance and a saturating reject count.
// Optional reject interrupt: define MCB_REJECT_IRQ_EN.
module monotonic_counter_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned REJ_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [31:0]      MAGIC     = 32'hDEAD_10CC;
    localparam logic [63:0]      CNT_MAX64 = (64'd1 << WIDTH) - 64'd1;
    localparam logic [31:0]      HI_MASK   = ~CNT_MAX64[31:0];
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [REJ_W-1:0] REJ_MAX   = '1;

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] sat_q, sat_d;
    logic [CHANNELS-1:0] locked_q, locked_d;
    logic [CHANNELS-1:0] rv_q, rv_d;
    logic [CHANNELS-1:0] acc_q, acc_d;
    logic                glock_q, glock_d;
    logic [REJ_W-1:0]    rej_q, rej_d;
    logic [31:0]         rd_d;
    logic                rej_evt;

    logic [3:0]       page;
    logic [3:0]       off;
    logic [WIDTH-1:0] wval;
    logic             val_ok;

    assign page   = addr[7:4];
    assign off    = addr[3:0];
    assign wval   = wdata[WIDTH-1:0];
    // Upper bits beyond WIDTH must be clear so a large value cannot alias to a small one
    assign val_ok = (wdata & HI_MASK) == 32'h0;

`ifdef MCB_REJECT_IRQ_EN
    logic irq_q, irq_d;
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Next-state for counters, flags, locks and reject counter
    always_comb begin
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        locked_d = locked_q;
        rv_d     = rv_q;
        acc_d    = acc_q;
        glock_d  = glock_q;
        rej_d    = rej_q;
        rej_evt  = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (we && page == 4'(c + 1)) begin
                case (off)
                    4'h0: begin
                        if (!(locked_q[c] || glock_q) && val_ok && wval > cnt_q[c])
                            cnt_d[c] = wval;
                    end
                    4'h4: begin
                        if (!(locked_q[c] || glock_q) && wdata[0]) begin
                            if (cnt_q[c] == CNT_MAX) sat_d[c] = 1'b1;
                            else                     cnt_d[c] = cnt_q[c] + WIDTH'(1);
                        end
                    end
                    4'h8: begin
                        rv_d[c] = 1'b1;
                        if (!(locked_q[c] || glock_q) && val_ok && wval > cnt_q[c]) begin
                            cnt_d[c] = wval;
                            acc_d[c] = 1'b1;
                        end else begin
                            acc_d[c] = 1'b0;
                            rej_evt  = 1'b1;
                        end
                    end
                    4'hC: begin
                        if (!(locked_q[c] || glock_q) && wdata == MAGIC)
                            locked_d[c] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        if (we && page == 4'h0) begin
            case (off)
                4'h4:    if (wdata == MAGIC) glock_d = 1'b1;
                4'h8:    if (!glock_q) rej_d = '0;
                default: ;
            endcase
        end
        if (rej_evt && rej_q != REJ_MAX)
            rej_d = rej_q + REJ_W'(1);
    end

`ifdef MCB_REJECT_IRQ_EN
    // W1C clear first so a simultaneous reject keeps the flag set
    always_comb begin
        irq_d = irq_q;
        if (we && page == 4'h0 && off == 4'hC && wdata[0])
            irq_d = 1'b0;
        if (rej_evt)
            irq_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end
`endif

    // Read mux sees pre-write state, so a same-cycle write is not visible
    always_comb begin
        rd_d = 32'h0;
        if (page == 4'h0) begin
            case (off)
                4'h0:    rd_d = {16'h0, 8'(CHANNELS), 8'(WIDTH)};
                4'h8:    rd_d = 32'(rej_q);
`ifdef MCB_REJECT_IRQ_EN
                4'hC:    rd_d = {31'h0, irq_q};
`endif
                default: rd_d = 32'h0;
            endcase
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (page == 4'(c + 1)) begin
                case (off)
                    4'h0:    rd_d = 32'(cnt_q[c]);
                    4'h8:    rd_d = {30'h0, rv_q[c], acc_q[c]};
                    4'hC:    rd_d = {29'h0, glock_q, sat_q[c], locked_q[c]};
                    default: rd_d = 32'h0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
            sat_q    <= '0;
            locked_q <= '0;
            rv_q     <= '0;
            acc_q    <= '0;
            glock_q  <= 1'b0;
            rej_q    <= '0;
            rdata    <= 32'h0;
        end else begin
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            locked_q <= locked_d;
            rv_q     <= rv_d;
            acc_q    <= acc_d;
            glock_q  <= glock_d;
            rej_q    <= rej_d;
            if (re) rdata <= rd_d;
        end
    end

endmodule

// File: tb/tb_monotonic_counter_bank.sv
// Scoreboard bench: two bank configurations driven by one bus, checked against a behavioural model.
module tb_monotonic_counter_bank;

    localparam logic [31:0] MAGIC = 32'hDEAD_10CC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = 8'h0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata0, rdata1;
    logic        irq0, irq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    monotonic_counter_bank dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .re(re),
        .wdata(wdata), .rdata(rdata0), .irq(irq0)
    );

    monotonic_counter_bank #(.CHANNELS(4), .WIDTH(8), .REJ_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .re(re),
        .wdata(wdata), .rdata(rdata1), .irq(irq1)
    );

    // Reference model: index 0 = 32-bit/16-bit-reject bank, index 1 = 8-bit/3-bit-reject bank
    int              wid  [2] = '{32, 8};
    int              rejw [2] = '{16, 3};
    longint unsigned mval [2][4];
    bit              msat [2][4];
    bit              mlck [2][4];
    bit              mrv  [2][4];
    bit              macc [2][4];
    bit              mglk [2];
    longint unsigned mrej [2];
    bit              mirq [2];

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        irq0;
        logic        irq1;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 4; c++) begin
                mval[i][c] = 0; msat[i][c] = 0; mlck[i][c] = 0; mrv[i][c] = 0; macc[i][c] = 0;
            end
            mglk[i] = 0; mrej[i] = 0; mirq[i] = 0;
        end
    endtask

    task automatic model_op(input int i, input bit w, input logic [7:0] a,
                            input logic [31:0] wd, output logic [31:0] rd);
        longint unsigned maxv = (64'd1 << wid[i]) - 1;
        longint unsigned rmax = (64'd1 << rejw[i]) - 1;
        longint unsigned wl   = 64'(wd);
        int  pg  = int'(a) / 16;
        int  of  = int'(a) % 16;
        int  c   = pg - 1;
        bit  chv = (pg >= 1) && (pg <= 4);
        bit  ali = (int'(a) % 4) == 0;
        bit  lk, fresh;
        rd = 32'h0;
        if (ali && pg == 0) begin
            if (of == 0) rd = 32'h400 | 32'(wid[i]);
            if (of == 8) rd = 32'(mrej[i]);
`ifdef MCB_REJECT_IRQ_EN
            if (of == 12) rd = 32'(mirq[i]);
`endif
        end else if (ali && chv) begin
            if (of == 0)  rd = 32'(mval[i][c]);
            if (of == 8)  rd = 32'(mrv[i][c]) * 2 + 32'(macc[i][c]);
            if (of == 12) rd = 32'(mglk[i]) * 4 + 32'(msat[i][c]) * 2 + 32'(mlck[i][c]);
        end
        if (!w || !ali) return;
        if (pg == 0) begin
            if (of == 4 && wd == MAGIC) mglk[i] = 1;
            if (of == 8 && !mglk[i]) mrej[i] = 0;
`ifdef MCB_REJECT_IRQ_EN
            if (of == 12 && wd[0]) mirq[i] = 0;
`endif
        end else if (chv) begin
            lk    = mlck[i][c] || mglk[i];
            fresh = !lk && wl <= maxv && wl > mval[i][c];
            if (of == 0 && fresh) mval[i][c] = wl;
            if (of == 4 && !lk && wd[0]) begin
                if (mval[i][c] == maxv) msat[i][c] = 1;
                else                    mval[i][c] = mval[i][c] + 1;
            end
            if (of == 8) begin
                mrv[i][c] = 1;
                macc[i][c] = fresh;
                if (fresh) mval[i][c] = wl;
                else begin
                    if (mrej[i] < rmax) mrej[i] = mrej[i] + 1;
`ifdef MCB_REJECT_IRQ_EN
                    mirq[i] = 1;
`endif
                end
            end
            if (of == 12 && !lk && wd == MAGIC) mlck[i][c] = 1;
        end
    endtask

    // One bus cycle; a read pushes its expected response for the monitor
    task automatic op(input bit w, input bit r, input logic [7:0] a, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        we = w; re = r; addr = a; wdata = wd;
        model_op(0, w, a, wd, e.rd0);
        model_op(1, w, a, wd, e.rd1);
        e.addr = a;
        e.irq0 = mirq[0];
        e.irq1 = mirq[1];
        if (r) sb.push_back(e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] wd); op(1, 0, a, wd); endtask
    task automatic rd(input logic [7:0] a);                        op(0, 1, a, 32'h0); endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            we = 0; re = 0;
        end
    endtask

    task automatic do_reset();
        idle(2);
        rst_n = 0;
        model_reset();
        idle(3);
        chk("reset rdata0", rdata0, 32'h0);
        chk("reset rdata1", rdata1, 32'h0);
        chk("reset irq", {30'h0, irq1, irq0}, 32'h0);
        rst_n = 1;
    endtask

    // Monitor: any cycle that sampled re out of reset yields one registered response
    initial begin
        exp_t e;
        bit   pend;
        forever begin
            @(posedge clk);
            pend = re && rst_n;
            @(negedge clk);
            if (pend) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: response with empty queue at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("rdata32 @%02h", e.addr), rdata0, e.rd0);
                    chk($sformatf("rdata8 @%02h", e.addr), rdata1, e.rd1);
                    chk($sformatf("irq32 @%02h", e.addr), 32'(irq0), 32'(e.irq0));
                    chk($sformatf("irq8 @%02h", e.addr), 32'(irq1), 32'(e.irq1));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        int          pg, of, c, m;

        do_reset();
        rd(8'h00);
        for (int k = 1; k <= 4; k++) rd(8'(k * 16));

        // ch0 increment then monotonic VALUE writes
        repeat (3) wr(8'h14, 32'h1);
        rd(8'h10);
        wr(8'h10, 32'd2);  rd(8'h10);
        wr(8'h10, 32'd10); rd(8'h10);

        // ch1 check-and-advance: accept, equal rejects, accept
        wr(8'h28, 32'd5); rd(8'h28);
        wr(8'h28, 32'd5); rd(8'h28);
        wr(8'h28, 32'd6); rd(8'h28);
        rd(8'h20); rd(8'h08); rd(8'h0C);

        // ch2 saturation in the narrow bank, out-of-range check
        wr(8'h30, 32'hFF); wr(8'h34, 32'h1);
        rd(8'h30); rd(8'h3C);
        wr(8'h38, 32'h100); rd(8'h38); rd(8'h08);

        // ch3 lock blocks everything but counts rejects; ch0 still advances
        wr(8'h4C, MAGIC);
        wr(8'h44, 32'h1); wr(8'h40, 32'd9); wr(8'h48, 32'd9);
        rd(8'h40); rd(8'h48); rd(8'h4C);
        wr(8'h14, 32'h1); rd(8'h10);

        // same-cycle read and write returns pre-write value
        op(1, 1, 8'h10, 32'd100); rd(8'h10);

        // unmapped and misaligned accesses
        wr(8'h50, 32'd5); wr(8'h12, 32'd50);
        rd(8'h50); rd(8'hF0); rd(8'h12); rd(8'h04); rd(8'h10);

        // reject-count clear and interrupt acknowledge
        wr(8'h0C, 32'h1); rd(8'h0C);
        wr(8'h08, 32'h0); rd(8'h08);

        // randomized traffic, rare lock keys, enough rejects to saturate the narrow counter
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            pg = $urandom_range(0, 5);
            of = $urandom_range(0, 3) * 4;
            if ($urandom_range(0, 19) == 0) of = of + $urandom_range(1, 3);
            a  = 8'(pg * 16 + of);
            c  = (pg >= 1 && pg <= 4) ? pg - 1 : 0;
            m  = $urandom_range(0, 4);
            case (m)
                0: d = 32'(mval[0][c] + 64'($urandom_range(0, 3)));
                1: d = 32'(mval[1][c] + 64'($urandom_range(0, 3)));
                2: d = $urandom_range(0, 300);
                3: d = $urandom;
                default: d = 32'($urandom_range(0, 1));
            endcase
            if ((of == 12 || (pg == 0 && of == 4)) && $urandom_range(0, 60) == 0) d = MAGIC;
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
        end
        idle(2);
        for (int k = 0; k < 16; k++) rd(8'(k * 4 + 16));
        rd(8'h08);

        // global lock blocks advances and reject-count clear
        do_reset();
        wr(8'h28, 32'd3); wr(8'h28, 32'd3);
        wr(8'h04, 32'h1234_5678); rd(8'h1C);
        wr(8'h04, MAGIC);
        wr(8'h14, 32'h1); wr(8'h10, 32'd77); wr(8'h18, 32'd78); wr(8'h08, 32'h0);
        rd(8'h10); rd(8'h18); rd(8'h1C); rd(8'h08); rd(8'h20);

        // reset in the middle of a CHECK write aborts it
        do_reset();
        wr(8'h10, 32'd7); wr(8'h1C, MAGIC);
        rd(8'h10);
        idle(2);
        @(negedge clk);
        we = 1; re = 0; addr = 8'h18; wdata = 32'd20;
        #2 rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        chk("midreset rdata0", rdata0, 32'h0);
        chk("midreset rdata1", rdata1, 32'h0);
        @(negedge clk);
        we = 0;
        rst_n = 1;
        rd(8'h10); rd(8'h18); rd(8'h1C); rd(8'h08);

        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
